// File: rtl/cirno9_mem_arb.sv
// cirno9_mem_arb: arbitrates the single SRAM port between instruction fetch (IF),
// execute-stage load/store (LS) and the external/debug port (EX).
// Fixed priority LS > IF > EX, with EX promoted to the top once it has lost
// STARVE_MAX arbitrations in a row. One access is in flight at a time. An
// access that gets no SRAM ready within TIMEOUT cycles completes with o_err.
module cirno9_mem_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch requester (read-only)
    input  logic        hs_if4arb_val,
    input  logic [31:0] i_if_adr,
    output logic        hs_arb4if_rdy,
    // load/store requester
    input  logic        hs_ls4arb_val,
    input  logic [31:0] i_ls_adr,
    input  logic [31:0] i_ls_wdat,
    input  logic [3:0]  i_ls_wen,
    input  logic        i_ls_ren,
    output logic        hs_arb4ls_rdy,
    // external/debug requester
    input  logic        hs_ex4arb_val,
    input  logic [31:0] i_ex_adr,
    input  logic [31:0] i_ex_wdat,
    input  logic [3:0]  i_ex_wen,
    input  logic        i_ex_ren,
    output logic        hs_arb4ex_rdy,
    // SRAM side
    output logic        o_sram_ren,
    output logic [3:0]  o_sram_wen,
    output logic [31:0] o_adr,
    output logic [31:0] o_wdat,
    input  logic [31:0] i_sram_rdat,
    input  logic        i_hs_ram4arb_rdy,
    // response
    output logic [31:0] o_rdat,
    output logic        o_err
);

    localparam logic [3:0] AgeMax   = 4'(STARVE_MAX);
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    // One-hot grant encoding shared by the arbiter and the latched grant
    localparam logic [2:0] GntNone = 3'b000;
    localparam logic [2:0] GntIf   = 3'b001;
    localparam logic [2:0] GntLs   = 3'b010;
    localparam logic [2:0] GntEx   = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  wen_q, wen_d;
    logic        ren_q, ren_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  age_q, age_d;
    logic [31:0] rdat_q, rdat_d;
    logic        err_q, err_d;

    logic [2:0]  pick;
    logic [31:0] win_adr;
    logic [31:0] win_wdat;
    logic [3:0]  win_wen;
    logic        win_ren;
    logic        is_read;

    // Arbitration over the live request lines; an aged-out EX overrides everyone
    always_comb begin
        pick = GntNone;
        if (hs_ex4arb_val && (age_q == AgeMax)) begin
            pick = GntEx;
        end else if (hs_ls4arb_val) begin
            pick = GntLs;
        end else if (hs_if4arb_val) begin
            pick = GntIf;
        end else if (hs_ex4arb_val) begin
            pick = GntEx;
        end
    end

    // Request fields of the arbitration winner; IF is always a plain read
    always_comb begin
        win_adr  = 32'h0;
        win_wdat = 32'h0;
        win_wen  = 4'h0;
        win_ren  = 1'b0;
        unique case (pick)
            GntIf: begin
                win_adr = i_if_adr;
                win_ren = 1'b1;
            end
            GntLs: begin
                win_adr  = i_ls_adr;
                win_wdat = i_ls_wdat;
                win_wen  = i_ls_wen;
                win_ren  = i_ls_ren;
            end
            GntEx: begin
                win_adr  = i_ex_adr;
                win_wdat = i_ex_wdat;
                win_wen  = i_ex_wen;
                win_ren  = i_ex_ren;
            end
            default: begin
                win_adr  = 32'h0;
                win_wdat = 32'h0;
                win_wen  = 4'h0;
                win_ren  = 1'b0;
            end
        endcase
    end

    // A latched access is a read only when no byte write is requested (write wins)
    assign is_read = ren_q && (wen_q == 4'h0);

    // Next-state logic: grant, request latch, wait/aging counters, response regs
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        wen_d   = wen_q;
        ren_d   = ren_q;
        wait_d  = wait_q;
        age_d   = age_q;
        rdat_d  = rdat_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick != GntNone) begin
                    grant_d = pick;
                    adr_d   = win_adr;
                    wdat_d  = win_wdat;
                    wen_d   = win_wen;
                    ren_d   = win_ren;
                    // Aging only moves when EX actually competed this round
                    if (pick == GntEx) begin
                        age_d = 4'h0;
                    end else if (hs_ex4arb_val && (age_q != AgeMax)) begin
                        age_d = age_q + 4'h1;
                    end
                    // Null access never touches the SRAM
                    if ((win_wen == 4'h0) && !win_ren) begin
                        rdat_d  = 32'h0;
                        state_d = StResp;
                    end else begin
                        wait_d  = 8'h0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (i_hs_ram4arb_rdy) begin
                    rdat_d  = is_read ? i_sram_rdat : 32'h0;
                    state_d = StResp;
                end else if (wait_q == WaitLast) begin
                    rdat_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 8'h1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= GntNone;
            adr_q   <= 32'h0;
            wdat_q  <= 32'h0;
            wen_q   <= 4'h0;
            ren_q   <= 1'b0;
            wait_q  <= 8'h0;
            age_q   <= 4'h0;
            rdat_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            wait_q  <= wait_d;
            age_q   <= age_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state: strobes only in ACCESS, pulse only in RESP
    always_comb begin
        o_sram_ren    = (state_q == StAccess) && is_read;
        o_sram_wen    = (state_q == StAccess) ? wen_q : 4'h0;
        hs_arb4if_rdy = (state_q == StResp) && grant_q[0];
        hs_arb4ls_rdy = (state_q == StResp) && grant_q[1];
        hs_arb4ex_rdy = (state_q == StResp) && grant_q[2];
    end

    assign o_adr  = adr_q;
    assign o_wdat = wdat_q;
    assign o_rdat = rdat_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// tb_cirno9_mem_arb: randomized requests from IF/LS/EX and a randomized SRAM
// responder, checked against a transaction-level model of the arbiter.
module tb_cirno9_mem_arb;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned TIMEOUT    = 64;
    localparam int          NTXN       = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hs_if4arb_val;
    logic [31:0] i_if_adr;
    logic        hs_arb4if_rdy;
    logic        hs_ls4arb_val;
    logic [31:0] i_ls_adr;
    logic [31:0] i_ls_wdat;
    logic [3:0]  i_ls_wen;
    logic        i_ls_ren;
    logic        hs_arb4ls_rdy;
    logic        hs_ex4arb_val;
    logic [31:0] i_ex_adr;
    logic [31:0] i_ex_wdat;
    logic [3:0]  i_ex_wen;
    logic        i_ex_ren;
    logic        hs_arb4ex_rdy;
    logic        o_sram_ren;
    logic [3:0]  o_sram_wen;
    logic [31:0] o_adr;
    logic [31:0] o_wdat;
    logic [31:0] i_sram_rdat;
    logic        i_hs_ram4arb_rdy;
    logic [31:0] o_rdat;
    logic        o_err;

    cirno9_mem_arb #(
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hs_if4arb_val   (hs_if4arb_val),
        .i_if_adr        (i_if_adr),
        .hs_arb4if_rdy   (hs_arb4if_rdy),
        .hs_ls4arb_val   (hs_ls4arb_val),
        .i_ls_adr        (i_ls_adr),
        .i_ls_wdat       (i_ls_wdat),
        .i_ls_wen        (i_ls_wen),
        .i_ls_ren        (i_ls_ren),
        .hs_arb4ls_rdy   (hs_arb4ls_rdy),
        .hs_ex4arb_val   (hs_ex4arb_val),
        .i_ex_adr        (i_ex_adr),
        .i_ex_wdat       (i_ex_wdat),
        .i_ex_wen        (i_ex_wen),
        .i_ex_ren        (i_ex_ren),
        .hs_arb4ex_rdy   (hs_arb4ex_rdy),
        .o_sram_ren      (o_sram_ren),
        .o_sram_wen      (o_sram_wen),
        .o_adr           (o_adr),
        .o_wdat          (o_wdat),
        .i_sram_rdat     (i_sram_rdat),
        .i_hs_ram4arb_rdy(i_hs_ram4arb_rdy),
        .o_rdat          (o_rdat),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    // Pending request per requester: 0 = IF, 1 = LS, 2 = EX
    typedef struct {
        logic        vld;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  wen;
        logic        ren;
    } req_t;

    req_t req [3];
    int   age;
    int   checks   = 0;
    int   failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        hs_if4arb_val = req[0].vld;
        i_if_adr      = req[0].adr;
        hs_ls4arb_val = req[1].vld;
        i_ls_adr      = req[1].adr;
        i_ls_wdat     = req[1].wdat;
        i_ls_wen      = req[1].wen;
        i_ls_ren      = req[1].ren;
        hs_ex4arb_val = req[2].vld;
        i_ex_adr      = req[2].adr;
        i_ex_wdat     = req[2].wdat;
        i_ex_wen      = req[2].wen;
        i_ex_ren      = req[2].ren;
    endtask

    // Garbage on the granted requester's lines; the latched copy must be used
    task automatic scramble(input int w);
        case (w)
            0: begin
                hs_if4arb_val = 1'($urandom_range(0, 1));
                i_if_adr      = $urandom;
            end
            1: begin
                hs_ls4arb_val = 1'($urandom_range(0, 1));
                i_ls_adr      = $urandom;
                i_ls_wdat     = $urandom;
                i_ls_wen      = 4'($urandom);
                i_ls_ren      = 1'($urandom_range(0, 1));
            end
            default: begin
                hs_ex4arb_val = 1'($urandom_range(0, 1));
                i_ex_adr      = $urandom;
                i_ex_wdat     = $urandom;
                i_ex_wen      = 4'($urandom);
                i_ex_ren      = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic gen_new();
        int kind;
        for (int k = 0; k < 3; k++) begin
            if (!req[k].vld && ($urandom_range(0, 3) != 0)) begin
                req[k].vld  = 1'b1;
                req[k].adr  = $urandom;
                req[k].wdat = $urandom;
                req[k].wen  = 4'h0;
                req[k].ren  = 1'b1;
                if (k != 0) begin
                    kind = int'($urandom_range(0, 7));
                    if (kind == 0) begin
                        req[k].ren = 1'b0;
                    end else if (kind == 1) begin
                        req[k].wen = 4'($urandom_range(1, 15));
                    end else if (kind <= 4) begin
                        req[k].wen = 4'($urandom_range(1, 15));
                        req[k].ren = 1'b0;
                    end
                end
            end
        end
    endtask

    // Fixed priority LS > IF > EX unless EX has lost STARVE_MAX rounds in a row
    function automatic int pick_winner();
        if (req[2].vld && (age == STARVE_MAX)) return 2;
        if (req[1].vld) return 1;
        if (req[0].vld) return 0;
        if (req[2].vld) return 2;
        return -1;
    endfunction

    task automatic check_rdys(input string tag, input int w);
        check_eq({tag, "_if_rdy"}, 32'(hs_arb4if_rdy), 32'(w == 0));
        check_eq({tag, "_ls_rdy"}, 32'(hs_arb4ls_rdy), 32'(w == 1));
        check_eq({tag, "_ex_rdy"}, 32'(hs_arb4ex_rdy), 32'(w == 2));
    endtask

    initial begin
        int          w;
        int          lat;
        int          ncyc;
        logic        rd;
        logic        nul;
        logic        tmo;
        logic        aborted;
        logic [31:0] exp_rdat;
        logic [31:0] last_adr;
        req_t        cur;

        for (int k = 0; k < 3; k++) begin
            req[k] = '{vld: 1'b0, adr: 32'h0, wdat: 32'h0, wen: 4'h0, ren: 1'b0};
        end
        drive_reqs();
        i_sram_rdat      = 32'h0;
        i_hs_ram4arb_rdy = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_sram_ren", 32'(o_sram_ren), 32'h0);
        check_eq("rst_sram_wen", 32'(o_sram_wen), 32'h0);
        check_eq("rst_adr", o_adr, 32'h0);
        check_eq("rst_wdat", o_wdat, 32'h0);
        check_eq("rst_rdat", o_rdat, 32'h0);
        check_eq("rst_err", 32'(o_err), 32'h0);
        check_rdys("rst", -1);

        rst_n    = 1'b1;
        age      = 0;
        last_adr = 32'h0;

        for (int t = 0; t < NTXN; t++) begin
            // Current cycle is IDLE
            gen_new();
            drive_reqs();
            check_eq("idle_sram_ren", 32'(o_sram_ren), 32'h0);
            check_eq("idle_sram_wen", 32'(o_sram_wen), 32'h0);
            check_eq("idle_err", 32'(o_err), 32'h0);
            check_eq("idle_adr", o_adr, last_adr);
            check_rdys("idle", -1);

            w = pick_winner();
            if (w < 0) begin
                @(negedge clk);
                continue;
            end
            if (w == 2) begin
                age = 0;
            end else if (req[2].vld && (age < STARVE_MAX)) begin
                age++;
            end
            cur      = req[w];
            last_adr = cur.adr;
            nul      = (cur.wen == 4'h0) && !cur.ren;
            rd       = cur.ren && (cur.wen == 4'h0);
            tmo      = 1'b0;
            aborted  = 1'b0;
            exp_rdat = 32'h0;

            if (!nul) begin
                lat = int'($urandom_range(0, 15));
                if (lat == 0) begin
                    lat = TIMEOUT;
                end else if (lat == 1) begin
                    lat = TIMEOUT - 1;
                end else begin
                    lat = int'($urandom_range(0, 3));
                end
                tmo  = (lat >= TIMEOUT);
                ncyc = tmo ? TIMEOUT : lat + 1;
                for (int i = 0; i < ncyc; i++) begin
                    @(negedge clk);
                    check_eq("acc_sram_ren", 32'(o_sram_ren), 32'(rd));
                    check_eq("acc_sram_wen", 32'(o_sram_wen), 32'(cur.wen));
                    check_eq("acc_adr", o_adr, cur.adr);
                    if (w != 0) check_eq("acc_wdat", o_wdat, cur.wdat);
                    check_eq("acc_err", 32'(o_err), 32'h0);
                    check_rdys("acc", -1);
                    if ((i == 0) && ((t == 60) || (t == 200))) begin
                        // Abandon the in-flight access with an asynchronous reset
                        rst_n = 1'b0;
                        #1;
                        check_eq("mid_rst_sram_ren", 32'(o_sram_ren), 32'h0);
                        check_eq("mid_rst_sram_wen", 32'(o_sram_wen), 32'h0);
                        check_eq("mid_rst_rdat", o_rdat, 32'h0);
                        check_eq("mid_rst_adr", o_adr, 32'h0);
                        check_rdys("mid_rst", -1);
                        i_hs_ram4arb_rdy = 1'b0;
                        @(negedge clk);
                        rst_n    = 1'b1;
                        age      = 0;
                        last_adr = 32'h0;
                        aborted  = 1'b1;
                        break;
                    end
                    i_sram_rdat      = $urandom;
                    i_hs_ram4arb_rdy = (i == lat);
                    if (i == lat) exp_rdat = rd ? i_sram_rdat : 32'h0;
                    scramble(w);
                end
            end
            if (aborted) continue;

            @(negedge clk);
            // Current cycle is RESP
            i_hs_ram4arb_rdy = 1'b0;
            check_rdys("resp", w);
            check_eq("resp_err", 32'(o_err), 32'(tmo));
            check_eq("resp_rdat", o_rdat, exp_rdat);
            check_eq("resp_sram_ren", 32'(o_sram_ren), 32'h0);
            check_eq("resp_sram_wen", 32'(o_sram_wen), 32'h0);
            check_eq("resp_adr", o_adr, cur.adr);
            req[w].vld = 1'b0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
